// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// wb_pkg : grant states and constants shared by the Wishbone 2:1 arbiter
// Rev 1.0
// ============================================================================
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } grant_e;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
// wb_watchdog : counts unanswered strobe cycles and flags a one-cycle expiry
// Rev 1.0
// ============================================================================
module wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_stb,
    input  logic i_ack,
    input  logic i_err,
    output logic o_expire,
    output logic o_timeout_err
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_bypass
            logic w_unused;
            assign w_unused      = ^{clk_i, rst_ni, i_stb, i_ack, i_err};
            assign o_expire      = 1'b0;
            assign o_timeout_err = 1'b0;
        end else begin : g_counter
            localparam int            CW     = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] r_count;
            logic          w_expire;

            // Expiry deliberately ignores ack so stb masking has no path from the slave response.
            assign w_expire = i_stb && (r_count == C_LAST);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_count <= '0;
                end else if (!i_stb || i_ack || i_err || w_expire) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign o_expire      = w_expire;
            assign o_timeout_err = w_expire && !i_ack;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// wb_arbiter_2to1 : round-robin sharing of one Wishbone slave by the I and D masters
// Rev 1.0
// ============================================================================
module wb_arbiter_2to1
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] iwbs_addr_i,
    input  logic                  iwbs_cyc_i,
    input  logic                  iwbs_stb_i,
    output logic [31:0]           iwbs_dat_o,
    output logic                  iwbs_ack_o,
    output logic                  iwbs_err_o,
    input  logic [ADDR_WIDTH-1:0] dwbs_addr_i,
    input  logic [31:0]           dwbs_dat_i,
    input  logic [3:0]            dwbs_sel_i,
    input  logic                  dwbs_cyc_i,
    input  logic                  dwbs_stb_i,
    input  logic                  dwbs_we_i,
    output logic [31:0]           dwbs_dat_o,
    output logic                  dwbs_ack_o,
    output logic                  dwbs_err_o,
    output logic [ADDR_WIDTH-1:0] wbm_addr_o,
    output logic [31:0]           wbm_dat_o,
    output logic [3:0]            wbm_sel_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    input  logic [31:0]           wbm_dat_i,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i
);

    grant_e r_state;
    grant_e w_state_nxt;
    logic   r_last_d;       // 1 when the data master held the most recent grant
    logic   w_gnt_i;
    logic   w_gnt_d;
    logic   w_req_stb;
    logic   w_expire;
    logic   w_timeout_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (w_state_nxt)
                GNT_I:   r_last_d <= 1'b0;
                GNT_D:   r_last_d <= 1'b1;
                default: ;
            endcase
        end
    end

    // A grant is held for the whole cyc; on release it hands straight over to a waiting master.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (iwbs_cyc_i && dwbs_cyc_i) begin
                    w_state_nxt = r_last_d ? GNT_I : GNT_D;
                end else if (iwbs_cyc_i) begin
                    w_state_nxt = GNT_I;
                end else if (dwbs_cyc_i) begin
                    w_state_nxt = GNT_D;
                end
            end
            GNT_I: begin
                if (!iwbs_cyc_i) begin
                    w_state_nxt = dwbs_cyc_i ? GNT_D : IDLE;
                end
            end
            GNT_D: begin
                if (!dwbs_cyc_i) begin
                    w_state_nxt = iwbs_cyc_i ? GNT_I : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_gnt_i = (r_state == GNT_I);
    assign w_gnt_d = (r_state == GNT_D);

    always_comb begin
        wbm_addr_o = '0;
        wbm_dat_o  = '0;
        wbm_sel_o  = '0;
        wbm_cyc_o  = 1'b0;
        wbm_we_o   = 1'b0;
        w_req_stb  = 1'b0;
        case (r_state)
            GNT_I: begin
                wbm_addr_o = iwbs_addr_i;
                wbm_sel_o  = WB_SEL_ALL;
                wbm_cyc_o  = iwbs_cyc_i;
                w_req_stb  = iwbs_stb_i;
            end
            GNT_D: begin
                wbm_addr_o = dwbs_addr_i;
                wbm_dat_o  = dwbs_dat_i;
                wbm_sel_o  = dwbs_sel_i;
                wbm_cyc_o  = dwbs_cyc_i;
                wbm_we_o   = dwbs_we_i;
                w_req_stb  = dwbs_stb_i;
            end
            default: ;
        endcase
    end

    wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .i_stb         (w_req_stb),
        .i_ack         (wbm_ack_i),
        .i_err         (wbm_err_i),
        .o_expire      (w_expire),
        .o_timeout_err (w_timeout_err)
    );

    assign wbm_stb_o  = w_req_stb && !w_expire;

    assign iwbs_ack_o = w_gnt_i && wbm_ack_i;
    assign iwbs_err_o = w_gnt_i && (wbm_err_i || w_timeout_err);
    assign dwbs_ack_o = w_gnt_d && wbm_ack_i;
    assign dwbs_err_o = w_gnt_d && (wbm_err_i || w_timeout_err);

    // Read data is broadcast, but held at zero while reset is asserted.
    assign iwbs_dat_o = rst_ni ? wbm_dat_i : '0;
    assign dwbs_dat_o = rst_ni ? wbm_dat_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_2to1.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_wb_arbiter_2to1 : directed bench with a cycle model of the 2:1 arbiter
// Rev 1.0
// ============================================================================
module tb_wb_arbiter_2to1;

    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, ddat = '0;
    logic [3:0]  dsel = '0;
    logic        icyc = 1'b0, istb = 1'b0, dcyc = 1'b0, dstb = 1'b0, dwe = 1'b0;

    logic [31:0] i_dat, d_dat, m_addr, m_dat;
    logic [3:0]  m_sel;
    logic        i_ack, i_err, d_ack, d_err, m_cyc, m_stb, m_we;

    logic [31:0] z_idat, z_ddat, z_addr, z_dat;
    logic [3:0]  z_sel;
    logic        z_iack, z_ierr, z_dack, z_derr, z_cyc, z_stb, z_we;
    logic        z_zero = 1'b0;

    logic [31:0] s_dat = '0;
    logic        s_resp, s_ack, s_err;
    int          slave_wait = 0;
    bit          slave_en = 1'b1, slave_errmode = 1'b0;
    int          wcnt = 0;
    int          cyc_n = 0;

    int n_chk = 0, n_fail = 0;

    wb_arbiter_2to1 #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .iwbs_addr_i(iaddr), .iwbs_cyc_i(icyc), .iwbs_stb_i(istb),
        .iwbs_dat_o(i_dat), .iwbs_ack_o(i_ack), .iwbs_err_o(i_err),
        .dwbs_addr_i(daddr), .dwbs_dat_i(ddat), .dwbs_sel_i(dsel), .dwbs_cyc_i(dcyc),
        .dwbs_stb_i(dstb), .dwbs_we_i(dwe),
        .dwbs_dat_o(d_dat), .dwbs_ack_o(d_ack), .dwbs_err_o(d_err),
        .wbm_addr_o(m_addr), .wbm_dat_o(m_dat), .wbm_sel_o(m_sel), .wbm_cyc_o(m_cyc),
        .wbm_stb_o(m_stb), .wbm_we_o(m_we),
        .wbm_dat_i(s_dat), .wbm_ack_i(s_ack), .wbm_err_i(s_err)
    );

    // Second instance with the watchdog disabled and a slave that never answers.
    wb_arbiter_2to1 #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_nowd (
        .clk_i(clk), .rst_ni(rst_ni),
        .iwbs_addr_i(iaddr), .iwbs_cyc_i(icyc), .iwbs_stb_i(istb),
        .iwbs_dat_o(z_idat), .iwbs_ack_o(z_iack), .iwbs_err_o(z_ierr),
        .dwbs_addr_i(daddr), .dwbs_dat_i(ddat), .dwbs_sel_i(dsel), .dwbs_cyc_i(dcyc),
        .dwbs_stb_i(dstb), .dwbs_we_i(dwe),
        .dwbs_dat_o(z_ddat), .dwbs_ack_o(z_dack), .dwbs_err_o(z_derr),
        .wbm_addr_o(z_addr), .wbm_dat_o(z_dat), .wbm_sel_o(z_sel), .wbm_cyc_o(z_cyc),
        .wbm_stb_o(z_stb), .wbm_we_o(z_we),
        .wbm_dat_i(s_dat), .wbm_ack_i(z_zero), .wbm_err_i(z_zero)
    );

    // Slave: answers after slave_wait unanswered strobe cycles.
    assign s_resp = slave_en && m_stb && (wcnt == slave_wait);
    assign s_ack  = s_resp && !slave_errmode;
    assign s_err  = s_resp && slave_errmode;

    always @(posedge clk) begin
        wcnt  <= (m_stb && !s_resp) ? wcnt + 1 : 0;
        s_dat <= $urandom;
        cyc_n <= cyc_n + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: owner/last as master ids (0 none, 1 I, 2 D), m_wd = unanswered strobe cycles.
    int   m_own = 0, m_last = 1, m_wd = 0, pref;
    bit   req [0:2];
    logic e_gi, e_gd, e_rstb, e_exp;

    always @(negedge clk) begin
        if (!rst_ni) begin
            m_own = 0; m_last = 1; m_wd = 0;
        end
        e_gi   = rst_ni && (m_own == 1);
        e_gd   = rst_ni && (m_own == 2);
        e_rstb = e_gi ? istb : (e_gd ? dstb : 1'b0);
        e_exp  = e_rstb && (m_wd == TO - 1);
        chk("wbm_cyc_o",  m_cyc,  e_gi ? icyc : (e_gd ? dcyc : 1'b0));
        chk("wbm_stb_o",  m_stb,  e_rstb && !e_exp);
        chk("wbm_we_o",   m_we,   e_gd && dwe);
        chk("wbm_addr_o", m_addr, e_gi ? iaddr : (e_gd ? daddr : 32'd0));
        chk("wbm_dat_o",  m_dat,  e_gd ? ddat : 32'd0);
        chk("wbm_sel_o",  m_sel,  e_gi ? 4'hF : (e_gd ? dsel : 4'h0));
        chk("iwbs_ack_o", i_ack,  e_gi && s_ack);
        chk("iwbs_err_o", i_err,  e_gi && (s_err || (e_exp && !s_ack)));
        chk("dwbs_ack_o", d_ack,  e_gd && s_ack);
        chk("dwbs_err_o", d_err,  e_gd && (s_err || (e_exp && !s_ack)));
        chk("iwbs_dat_o", i_dat,  rst_ni ? s_dat : 32'd0);
        chk("dwbs_dat_o", d_dat,  rst_ni ? s_dat : 32'd0);
        if (rst_ni) begin
            m_wd = (e_rstb && !s_ack && !s_err && !e_exp) ? m_wd + 1 : 0;
            req[0] = 1'b0; req[1] = icyc; req[2] = dcyc;
            if (!req[m_own]) begin
                pref = 3 - m_last;     // the master served less recently goes first
                if (req[pref])          m_own = pref;
                else if (req[3 - pref]) m_own = 3 - pref;
                else                    m_own = 0;
                if (m_own != 0) m_last = m_own;
            end
        end
    end

    // Event recorder for the directed checks.
    int c_iack = 0, c_dack = 0, c_ierr = 0, c_derr = 0;
    int ev_cyc [$];
    int ev_m [$];
    bit track = 1'b0, d_prev = 1'b0;
    int d_drop = -1, gi_cyc = -1;

    always @(negedge clk) begin
        if (i_ack) begin c_iack++; ev_cyc.push_back(cyc_n); ev_m.push_back(1); end
        if (d_ack) begin c_dack++; ev_cyc.push_back(cyc_n); ev_m.push_back(2); end
        if (i_err) c_ierr++;
        if (d_err) c_derr++;
        if (track) begin
            if (d_prev && !dcyc && d_drop < 0) d_drop = cyc_n;
            if (m_cyc && m_addr == 32'h0000_3000 && gi_cyc < 0) gi_cyc = cyc_n;
            d_prev = dcyc;
        end
    end

    task automatic clear_events();
        c_iack = 0; c_dack = 0; c_ierr = 0; c_derr = 0;
        ev_cyc.delete(); ev_m.delete();
    endtask

    task automatic drive(input int m, input logic c, input logic [31:0] a, input logic we);
        if (m == 1) begin
            icyc = c; istb = c; iaddr = a;
        end else begin
            dcyc = c; dstb = c; daddr = a; dwe = we;
            ddat = a ^ 32'h5A5A_0000; dsel = we ? 4'b0011 : 4'hF;
        end
    endtask

    task automatic wait_resp(input int m);
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = (m == 1) ? (i_ack || i_err) : (d_ack || d_err);
            @(posedge clk); #1;
        end
        chk("response_seen", {63'd0, got}, 64'd1);
    endtask

    task automatic xfer(input int m, input logic [31:0] a, input int beats, input logic we);
        for (int b = 0; b < beats; b++) begin
            drive(m, 1'b1, a + 32'(4 * b), we);
            wait_resp(m);
        end
        drive(m, 1'b0, 32'd0, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int na, ni, ack_at;
        bit ok_alt;

        // Reset with both masters requesting
        icyc = 1; istb = 1; iaddr = 32'h1111_0000;
        dcyc = 1; dstb = 1; daddr = 32'h7000_0000; dwe = 1; ddat = 32'h1234; dsel = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc", m_cyc, 0); chk("rst_stb", m_stb, 0); chk("rst_we", m_we, 0);
        chk("rst_addr", m_addr, 0); chk("rst_idat", i_dat, 0); chk("rst_dack", d_ack, 0);
        @(posedge clk); #1; rst_ni = 1'b1;
        @(negedge clk);
        chk("rel_idle_cyc", m_cyc, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_gntd_cyc", m_cyc, 1); chk("rel_gntd_we", m_we, 1);
        chk("rel_gntd_addr", m_addr, 32'h7000_0000);
        chk("rel_gntd_dack", d_ack, 1); chk("rel_gntd_iack", i_ack, 0);
        @(posedge clk); #1;
        icyc = 0; istb = 0; dcyc = 0; dstb = 0; dwe = 0;
        repeat (2) @(posedge clk); #1;

        // Single data write, two wait states
        slave_wait = 2;
        daddr = 32'h8000_0010; ddat = 32'hDEAD_BEEF; dsel = 4'b0011; dwe = 1; dcyc = 1; dstb = 1;
        na = 0; ni = 0; ack_at = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (d_ack) begin na++; ack_at = k; end
            if (i_ack) ni++;
            if (k == 2) begin
                chk("wr_addr", m_addr, 32'h8000_0010); chk("wr_dat", m_dat, 32'hDEAD_BEEF);
                chk("wr_sel", m_sel, 4'b0011); chk("wr_we", m_we, 1);
            end
            @(posedge clk); #1;
            if (ack_at == k) begin dcyc = 0; dstb = 0; dwe = 0; end
        end
        chk("wr_ack_count", na, 1); chk("wr_ack_cycle", ack_at, 3); chk("wr_iack_count", ni, 0);

        // Slave error is routed to the granted master only
        clear_events(); slave_wait = 1; slave_errmode = 1;
        xfer(2, 32'h0000_0100, 1, 0);
        chk("err_derr", c_derr, 1); chk("err_dack", c_dack, 0); chk("err_ierr", c_ierr, 0);
        slave_errmode = 0;

        // Contention: alternate grants with no idle cycle between
        clear_events(); slave_wait = 0;
        fork
            begin repeat (3) xfer(1, 32'h0000_1000, 1, 0); end
            begin repeat (3) xfer(2, 32'h2000_0000, 1, 1); end
        join
        chk("alt_count", ev_m.size(), 6);
        ok_alt = 1'b1;
        for (int j = 0; j < ev_m.size(); j++) begin
            if (ev_m[j] != ((j % 2 == 0) ? 1 : 2)) ok_alt = 1'b0;
            if (j > 0 && (ev_cyc[j] - ev_cyc[j-1]) != 2) ok_alt = 1'b0;
        end
        chk("alt_order_spacing", {63'd0, ok_alt}, 64'd1);

        // Burst hold: instruction grant follows the data master's cyc release
        clear_events(); slave_wait = 1; d_drop = -1; gi_cyc = -1; d_prev = 0; track = 1;
        fork
            begin xfer(2, 32'h4000_0000, 4, 0); end
            begin repeat (2) @(posedge clk); #1; xfer(1, 32'h0000_3000, 1, 0); end
        join
        track = 0;
        chk("burst_dack", c_dack, 4); chk("burst_iack", c_iack, 1);
        chk("burst_gnt_i_cycle", gi_cyc, d_drop + 1);
        if (ev_m.size() == 5) chk("burst_i_last", ev_m[4], 1);
        else chk("burst_ev_count", ev_m.size(), 5);

        // Watchdog: slave never answers a fetch
        rst_ni = 0; repeat (2) @(posedge clk); #1; rst_ni = 1;
        slave_en = 0; icyc = 1; istb = 1; iaddr = 32'h0000_5000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("wd_ierr", i_err, (k == 8 || k == 16));
            chk("wd_stb", m_stb, (k >= 1 && k != 8 && k != 16));
            chk("nowd_ierr", z_ierr, 0);
            chk("nowd_stb", z_stb, (k >= 1));
            @(posedge clk); #1;
        end
        icyc = 0; istb = 0; slave_en = 1;
        repeat (2) @(posedge clk); #1;

        // Asynchronous reset in the middle of a data cycle
        slave_wait = 5; daddr = 32'h0000_6000; ddat = 32'hA5A5_0001; dsel = 4'hF; dwe = 1; dcyc = 1; dstb = 1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk("ar_pre_cyc", m_cyc, 1);
        clear_events();
        rst_ni = 0; #1;
        chk("ar_cyc", m_cyc, 0); chk("ar_stb", m_stb, 0);
        chk("ar_addr", m_addr, 0); chk("ar_ddat", d_dat, 0);
        @(posedge clk); #1;
        @(posedge clk); #1; rst_ni = 1;
        @(negedge clk);
        chk("ar_idle_after", m_cyc, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ar_regrant", m_cyc, 1);
        chk("ar_no_dack", c_dack, 0);
        @(posedge clk); #1;
        dcyc = 0; dstb = 0; dwe = 0;
        repeat (3) @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter_2to1.md
Name: wb_arbiter_2to1

Overview:
- Round-robin arbiter that shares one Wishbone classic slave port (single-port RAM or peripheral bus) between the CPU instruction master and data master.
- Holds a grant for the whole bus cycle (cyc), so block transfers are not interleaved.
- A bus watchdog returns err to the granted master when the slave does not respond.
- Sits between the core's iwbm/dwbm ports and a single-ported memory in testbench and SoC tops.

Parameters:
- ADDR_WIDTH, 32, address width on all ports.
- TIMEOUT_CYCLES, 255, cycles stb may wait for ack/err before the watchdog fires; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- iwbs_addr_i  in  ADDR_WIDTH  instruction master address.
- iwbs_cyc_i  in  1  instruction master cyc.
- iwbs_stb_i  in  1  instruction master stb.
- iwbs_dat_o  out  32  read data to instruction master.
- iwbs_ack_o  out  1  ack to instruction master.
- iwbs_err_o  out  1  err to instruction master.
- dwbs_addr_i  in  ADDR_WIDTH  data master address.
- dwbs_dat_i  in  32  data master write data.
- dwbs_sel_i  in  4  data master byte select.
- dwbs_cyc_i  in  1  data master cyc.
- dwbs_stb_i  in  1  data master stb.
- dwbs_we_i  in  1  data master write enable.
- dwbs_dat_o  out  32  read data to data master.
- dwbs_ack_o  out  1  ack to data master.
- dwbs_err_o  out  1  err to data master.
- wbm_addr_o  out  ADDR_WIDTH  shared bus address.
- wbm_dat_o  out  32  shared bus write data.
- wbm_sel_o  out  4  shared bus byte select.
- wbm_cyc_o  out  1  shared bus cyc.
- wbm_stb_o  out  1  shared bus stb.
- wbm_we_o  out  1  shared bus write enable.
- wbm_dat_i  in  32  shared bus read data.
- wbm_ack_i  in  1  shared bus ack.
- wbm_err_i  in  1  shared bus err.

Behaviour:
- Reset: state IDLE, last_grant=I, watchdog count=0. All outputs are 0 while rst_ni is low, including every cyc/stb/we/ack/err and all data buses. Reset asserted mid-transfer aborts it immediately; no ack is issued.
- FSM states: IDLE, GNT_I, GNT_D. The state register is the grant.
- IDLE:
  - Only iwbs_cyc_i high: go to GNT_I.
  - Only dwbs_cyc_i high: go to GNT_D.
  - Both high: grant the master that is not last_grant.
  - Grant latency is 1 cycle from the first cyc.
- GNT_x: hold while cyc_x stays high. When cyc_x is low at an edge:
  - Other master's cyc high: switch directly to its grant (no idle bubble).
  - Otherwise: go to IDLE.
  - On entering any GNT_x, set last_grant=x.
- Mux, combinational from state:
  - In GNT_I: wbm_addr_o=iwbs_addr_i, wbm_cyc_o/stb_o follow iwbs, wbm_we_o=0, wbm_sel_o=4'hF, wbm_dat_o=0.
  - In GNT_D: all wbm_* outputs follow dwbs_*.
  - In IDLE: wbm_cyc_o=wbm_stb_o=wbm_we_o=0; addr/dat/sel are don't-care and driven 0.
- Responses:
  - wbm_ack_i and wbm_err_i route only to the granted master. The non-granted master sees ack=err=0.
  - wbm_dat_i is broadcast to both iwbs_dat_o and dwbs_dat_o.
  - Ack in the same cycle as stb is allowed (zero-wait slave).
- Watchdog:
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - Increments each cycle wbm_stb_o=1 && !wbm_ack_i && !wbm_err_i; clears on ack, on err, or when stb is low.
  - When count==TIMEOUT_CYCLES-1 with no response, the arbiter asserts err to the granted master for exactly 1 cycle and clears the counter.
  - wbm_stb_o is forced low in that cycle so the slave sees the request withdrawn.
- Simultaneous events:
  - wbm_ack_i and a watchdog expiry in the same cycle: the ack wins and no err is issued.
  - wbm_err_i is passed through unchanged and is never counted as a timeout.
- A master that drops cyc with stb still pending forfeits the response. Any late ack from the slave is dropped once the state changes.
- No combinational path from wbm_ack_i to any wbm_* output.

Decomposition:
- Shared package (wb_pkg): grant state enum {IDLE, GNT_I, GNT_D} and WB_SEL_ALL=4'hF.
- One natural sub-module: wb_watchdog (counter, expiry pulse, TIMEOUT_CYCLES=0 bypass).
- The FSM and mux stay in wb_arbiter_2to1.

Test Plan:
- Reset: hold rst_ni=0 with both cyc high -> all outputs 0. Release -> GNT_D one cycle after release (last_grant reset value is I, so the other master wins).
- Single data write: dwbs addr=0x8000_0010, dat=0xDEADBEEF, sel=4'b0011, we=1; slave acks after 2 wait cycles -> wbm_* mirror dwbs_*, dwbs_ack_o pulses once, iwbs_ack_o stays 0.
- Contention: both cyc rise in the same cycle, each master does 3 single-beat transfers -> grants alternate I/D/I/D/I/D with no IDLE cycle between switches.
- Burst hold: data master keeps cyc high for 4 beats while the instruction master requests -> the instruction grant starts the cycle after dwbs_cyc_i falls.
- Timeout: TIMEOUT_CYCLES=8, slave never acks on a fetch -> iwbs_err_o=1 exactly on the 8th stb cycle, wbm_stb_o=0 in that cycle. With TIMEOUT_CYCLES=0 the arbiter waits indefinitely and never asserts err.
- Async reset mid-burst: rst_ni falls between clock edges during GNT_D -> wbm_cyc_o drops immediately (before the next edge), state is IDLE after release, and no ack reaches dwbs.
